// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the SDRAM request-port arbiter.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam int unsigned REQ_IFETCH = 0;
    localparam int unsigned REQ_DATA   = 1;
    localparam int unsigned REQ_LOADER = 2;

    // Width of a requester index; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker for dram_arbiter.
// Policy: ARB_RR_EN defined -> round-robin from (last + 1) mod NUM_REQ,
//         otherwise fixed priority with the lowest index winning.
module arb_pick
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               any_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic [NUM_REQ-1:0] onehot_c
);

`ifdef ARB_RR_EN
    // Rotating search: first valid requester after the last grant.
    always_comb begin
        logic        found;
        int unsigned cand;
        found = 1'b0;
        cand  = 0;
        idx_c = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_i) + k) % NUM_REQ;
            if (!found && valid_i[IDX_W'(cand)]) begin
                found = 1'b1;
                idx_c = IDX_W'(cand);
            end
        end
    end
`else
    // The last grant has no bearing on fixed priority.
    logic unused_last;
    assign unused_last = ^last_i;

    // Fixed priority: lowest valid index wins.
    always_comb begin
        logic found;
        found = 1'b0;
        idx_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && valid_i[IDX_W'(i)]) begin
                found = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end
`endif

    // Any-request flag and one-hot form of the winner.
    always_comb begin
        any_c    = |valid_i;
        onehot_c = any_c ? (NUM_REQ'(1) << idx_c) : '0;
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single SDRAM controller command port among NUM_REQ requesters,
// one transaction outstanding at a time. Arbitration policy lives in
// arb_pick and is selected by the ARB_RR_EN macro (round-robin when defined).
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_done,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      dram_ready
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_t          state_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    last_q;
    logic [NUM_REQ-1:0]  req_ready_q;
    logic [NUM_REQ-1:0]  req_done_q;
    logic [DATA_W-1:0]   req_rdata_q;
    logic                mem_valid_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                pick_any_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic [NUM_REQ-1:0]  pick_onehot_c;

    logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_a [NUM_REQ];

    // Unpack the flat payload buses into per-requester arrays.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_a[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i  (req_valid),
        .last_i   (last_q),
        .any_c    (pick_any_c),
        .idx_c    (pick_idx_c),
        .onehot_c (pick_onehot_c)
    );

    // Transaction FSM: grant and latch, issue to controller, await completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            req_ready_q <= '0;
            req_done_q  <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (dram_ready && pick_any_c) begin
                        grant_q     <= pick_idx_c;
                        last_q      <= pick_idx_c;
                        mem_we_q    <= req_we[pick_idx_c];
                        mem_addr_q  <= addr_a[pick_idx_c];
                        mem_wdata_q <= wdata_a[pick_idx_c];
                        req_ready_q <= pick_onehot_c;
                        mem_valid_q <= 1'b1;
                        state_q     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_done) begin
                        req_rdata_q <= mem_rdata;
                        req_done_q  <= NUM_REQ'(1) << grant_q;
                        state_q     <= ARB_IDLE;
                    end
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    state_q     <= ARB_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign req_done  = req_done_q;
    assign req_rdata = req_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small SDRAM controller model and a
// completion scoreboard. Expected grant order follows ARB_RR_EN.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_done;
    logic [DW-1:0]     req_rdata;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_done;
    logic [DW-1:0]     mem_rdata;
    logic              dram_ready = 1'b0;

    dram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .req_done   (req_done),
        .req_rdata  (req_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .dram_ready (dram_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [NR-1:0] oh;
        bit            is_read;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb_q[$];

`ifdef ARB_RR_EN
    int exp_g[3] = '{0, 1, 2};
`else
    int exp_g[3] = '{0, 0, 0};
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // SDRAM controller model
    logic [DW-1:0] sdram [int];
    int            mstate = 0;
    int            mcnt = 0;
    int            ready_delay = 3;
    int            done_delay = 2;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;

    function automatic logic [DW-1:0] sd_rd(input int a);
        return sdram.exists(a) ? sdram[a] : '0;
    endfunction

    initial begin
        mem_ready = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_done  = 1'b0;
            case (mstate)
                0: if (mem_valid === 1'b1) begin
                    mcnt = 1;
                    mstate = 1;
                end
                1: begin
                    if (mcnt >= ready_delay) begin
                        mem_ready = 1'b1;
                        m_addr = mem_addr;
                        m_we = mem_we;
                        m_wdata = mem_wdata;
                        mcnt = 0;
                        mstate = 2;
                    end else mcnt++;
                end
                default: begin
                    mcnt++;
                    if (mcnt >= done_delay) begin
                        mem_done = 1'b1;
                        if (m_we) sdram[int'(m_addr)] = m_wdata;
                        else mem_rdata = sd_rd(int'(m_addr));
                        mstate = 0;
                    end
                end
            endcase
        end
    end

    // Completion monitor: req_done must follow each mem_done by one cycle.
    logic mem_done_at_edge = 1'b0;
    logic rst_at_edge = 1'b1;
    always @(posedge clk) begin
        mem_done_at_edge <= mem_done;
        rst_at_edge      <= rst;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_at_edge) begin
                if (mem_done_at_edge) begin
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("done_onehot", 32'(req_done), 32'(e.oh));
                        if (e.is_read) check("done_rdata", 32'(req_rdata), 32'(e.rdata));
                    end else begin
                        check("late_done_ignored", 32'(req_done), 32'(0));
                    end
                end else if (req_done !== '0) begin
                    check("spurious_done", 32'(req_done), 32'(0));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push_exp(input int i, input bit is_read, input logic [DW-1:0] rd);
        exp_t e;
        e.oh = NR'(1) << i;
        e.is_read = is_read;
        e.rdata = rd;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(input logic [NR-1:0] exp, input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (req_ready === '0 && lat < 200);
        check({tag, "_ready"}, 32'(req_ready), 32'(exp));
    endtask

    task automatic wait_sb_empty(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(sb_q.size()), 32'(0));
        tick(2);
    endtask

    task automatic do_txn(input int i, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string tag);
        int lat;
        push_exp(i, !we, we ? '0 : sd_rd(int'(a)));
        set_req(i, 1'b1, we, a, d);
        wait_ready(NR'(1) << i, tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(1));
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'(1));
        check({tag, "_mem_we"}, 32'(mem_we), 32'(we));
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
        if (we) check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(d));
        set_req(i, 1'b0, 1'b0, '0, '0);
        tick(1);
        check({tag, "_ready_pulse"}, 32'(req_ready), 32'(0));
        wait_sb_empty(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        check({tag, "_req_done"}, 32'(req_done), 32'(0));
        check({tag, "_req_rdata"}, 32'(req_rdata), 32'(0));
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'(0));
        check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    endtask

    initial begin
        int lat;
        int n;
        bit seen;

        sdram[32'h05]  = 16'hA5A5;
        sdram[32'h1F]  = 16'h6002;
        sdram[32'h100] = 16'hB000;
        sdram[32'h101] = 16'hB001;
        sdram[32'h102] = 16'hB002;
        sdram[32'h22]  = 16'h1234;
        sdram[32'h31]  = 16'h7777;

        // 1: reset values, then no grant until dram_ready
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        set_req(REQ_IFETCH, 1'b1, 1'b0, 24'h000005, '0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (req_ready !== '0 || mem_valid !== 1'b0) seen = 1'b1;
        end
        check("no_grant_without_dram_ready", 32'(seen), 32'(0));
        push_exp(REQ_IFETCH, 1'b1, sd_rd(32'h05));
        dram_ready = 1'b1;
        wait_ready(3'b001, "t1", lat);
        check("t1_lat", 32'(lat), 32'(1));
        check("t1_mem_valid", 32'(mem_valid), 32'(1));
        set_req(REQ_IFETCH, 1'b0, 1'b0, '0, '0);
        wait_sb_empty("t1");

        // 2: read from the load/store port
        do_txn(REQ_DATA, 1'b0, 24'h00001F, '0, "t2");

        // 3: all requesters held for three grants
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, AW'(32'h100 + i), '0);
        for (int k = 0; k < 3; k++) begin
            push_exp(exp_g[k], 1'b1, sd_rd(32'h100 + exp_g[k]));
            wait_ready(NR'(1) << exp_g[k], $sformatf("t3_g%0d", k), lat);
            tick(1);
        end
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, '0, '0);
        wait_sb_empty("t3");

        // 4: write from the loader
        do_txn(REQ_LOADER, 1'b1, 24'h000011, 16'h4042, "t4");
        check("t4_sdram", 32'(sd_rd(32'h11)), 32'h4042);

        // 5: reset while waiting for completion; the late mem_done is dropped
        done_delay = 8;
        set_req(REQ_IFETCH, 1'b1, 1'b0, 24'h000022, '0);
        wait_ready(3'b001, "t5", lat);
        set_req(REQ_IFETCH, 1'b0, 1'b0, '0, '0);
        n = 0;
        while (mstate != 2 && n < 100) begin
            tick(1);
            n++;
        end
        check("t5_accepted", 32'(mstate), 32'(2));
        tick(1);
        rst = 1'b1;
        tick(1);
        check_all_zero("t5_rst");
        check("t5_state", 32'(dut.state_q), 32'(ARB_IDLE));
        rst = 1'b0;
        n = 0;
        while (mstate != 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(3);
        check("t5_sb_empty", 32'(sb_q.size()), 32'(0));
        done_delay = 2;

        // 6: requester 0 withdraws before any grant
        dram_ready = 1'b0;
        set_req(REQ_IFETCH, 1'b1, 1'b0, 24'h000030, '0);
        tick(2);
        set_req(REQ_DATA, 1'b1, 1'b0, 24'h000031, '0);
        tick(2);
        set_req(REQ_IFETCH, 1'b0, 1'b0, '0, '0);
        tick(1);
        push_exp(REQ_DATA, 1'b1, sd_rd(32'h31));
        dram_ready = 1'b1;
        wait_ready(3'b010, "t6", lat);
        check("t6_lat", 32'(lat), 32'(1));
        check("t6_mem_addr", 32'(mem_addr), 32'h31);
        set_req(REQ_DATA, 1'b0, 1'b0, '0, '0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (req_ready[REQ_IFETCH] !== 1'b0) seen = 1'b1;
        end
        check("t6_req0_never_ready", 32'(seen), 32'(0));
        wait_sb_empty("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
